// File: rtl/systolic_array.sv
// systolic_array: output-stationary 4x4 MAC grid, 32-bit operands, 64-bit accumulators (SYST_SIGNED_EN selects signed arithmetic)
module systolic_array (
  input  logic [31:0] a1,
  input  logic [31:0] a2,
  input  logic [31:0] a3,
  input  logic [31:0] a4,
  input  logic [31:0] b1,
  input  logic [31:0] b2,
  input  logic [31:0] b3,
  input  logic [31:0] b4,
  input  logic        clk,
  input  logic        rst,
  output logic [63:0] c1,
  output logic [63:0] c2,
  output logic [63:0] c3,
  output logic [63:0] c4,
  output logic [63:0] c5,
  output logic [63:0] c6,
  output logic [63:0] c7,
  output logic [63:0] c8,
  output logic [63:0] c9,
  output logic [63:0] c10,
  output logic [63:0] c11,
  output logic [63:0] c12,
  output logic [63:0] c13,
  output logic [63:0] c14,
  output logic [63:0] c15,
  output logic [63:0] c16
);

  logic [31:0] a_edge [4];
  logic [31:0] b_edge [4];
  logic [31:0] a_d    [4][4];
  logic [31:0] b_d    [4][4];
  logic [31:0] a_q    [4][4];
  logic [31:0] b_q    [4][4];
  logic [63:0] acc_d  [4][4];
  logic [63:0] acc_q  [4][4];

  // Truncating to 64 bits makes the signed and unsigned sums both wrap modulo 2^64.
  function automatic logic [63:0] mac(input logic [63:0] acc, input logic [31:0] x, input logic [31:0] y);
`ifdef SYST_SIGNED_EN
    logic signed [63:0] p;
    p = $signed({{32{x[31]}}, x}) * $signed({{32{y[31]}}, y});
    return acc + p;
`else
    return acc + {32'd0, x} * {32'd0, y};
`endif
  endfunction

  assign a_edge[0] = a1;
  assign a_edge[1] = a2;
  assign a_edge[2] = a3;
  assign a_edge[3] = a4;
  assign b_edge[0] = b1;
  assign b_edge[1] = b2;
  assign b_edge[2] = b3;
  assign b_edge[3] = b4;

  genvar i, j;
  generate
    for (i = 0; i < 4; i++) begin : g_row
      for (j = 0; j < 4; j++) begin : g_col
        if (j == 0) begin : g_a_edge
          assign a_d[i][j] = a_edge[i];
        end else begin : g_a_hop
          assign a_d[i][j] = a_q[i][j-1];
        end
        if (i == 0) begin : g_b_edge
          assign b_d[i][j] = b_edge[j];
        end else begin : g_b_hop
          assign b_d[i][j] = b_q[i-1][j];
        end
        assign acc_d[i][j] = mac(acc_q[i][j], a_d[i][j], b_d[i][j]);
      end
    end
  endgenerate

  // PE registers: latch incoming operands for the next hop and accumulate their product.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < 4; r++)
        for (int k = 0; k < 4; k++) begin
          a_q[r][k]   <= '0;
          b_q[r][k]   <= '0;
          acc_q[r][k] <= '0;
        end
    end else begin
      for (int r = 0; r < 4; r++)
        for (int k = 0; k < 4; k++) begin
          a_q[r][k]   <= a_d[r][k];
          b_q[r][k]   <= b_d[r][k];
          acc_q[r][k] <= acc_d[r][k];
        end
    end
  end

  assign c1  = acc_q[0][0];
  assign c2  = acc_q[0][1];
  assign c3  = acc_q[0][2];
  assign c4  = acc_q[0][3];
  assign c5  = acc_q[1][0];
  assign c6  = acc_q[1][1];
  assign c7  = acc_q[1][2];
  assign c8  = acc_q[1][3];
  assign c9  = acc_q[2][0];
  assign c10 = acc_q[2][1];
  assign c11 = acc_q[2][2];
  assign c12 = acc_q[2][3];
  assign c13 = acc_q[3][0];
  assign c14 = acc_q[3][1];
  assign c15 = acc_q[3][2];
  assign c16 = acc_q[3][3];

endmodule

// File: tb/tb_systolic_array.sv
// tb_systolic_array: directed self-checking bench for systolic_array
module tb_systolic_array;
  logic        clk = 0;
  logic        rst = 0;
  logic [31:0] a [4];
  logic [31:0] b [4];
  logic [63:0] c [16];
  logic [31:0] ma [4][4];
  logic [31:0] mb [4][4];
  int n_tests = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  systolic_array dut (
    .a1(a[0]), .a2(a[1]), .a3(a[2]), .a4(a[3]),
    .b1(b[0]), .b2(b[1]), .b3(b[2]), .b4(b[3]),
    .clk(clk), .rst(rst),
    .c1(c[0]), .c2(c[1]), .c3(c[2]), .c4(c[3]),
    .c5(c[4]), .c6(c[5]), .c7(c[6]), .c8(c[7]),
    .c9(c[8]), .c10(c[9]), .c11(c[10]), .c12(c[11]),
    .c13(c[12]), .c14(c[13]), .c15(c[14]), .c16(c[15])
  );

  task automatic check(input string tag, input int idx, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s c%0d observed=%h expected=%h", tag, idx + 1, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [63:0] exp);
    for (int n = 0; n < 16; n++) check(tag, n, c[n], exp);
  endtask

  task automatic zero_in();
    for (int n = 0; n < 4; n++) begin
      a[n] = 0;
      b[n] = 0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    zero_in();
    rst = 0;
    tick();
    rst = 1;
  endtask

  task automatic step_prod(input int t);
    for (int n = 0; n < 4; n++) begin
      a[n] = (t - n >= 0 && t - n < 4) ? ma[n][t-n] : 32'd0;
      b[n] = (t - n >= 0 && t - n < 4) ? mb[t-n][n] : 32'd0;
    end
    tick();
  endtask

  task automatic run_prod(input int t0, input int t1);
    for (int t = t0; t <= t1; t++) step_prod(t);
    zero_in();
  endtask

  initial begin
    zero_in();
    a[0] = 7;
    b[0] = 7;
    rst = 0;
    #1;
    check_all("async_reset", 64'd0);
    tick(); tick(); tick();
    check_all("reset_hold", 64'd0);
    rst = 1;
    tick();
    check("reset_release", 0, c[0], 64'd49);
    for (int n = 1; n < 16; n++) check("reset_release", n, c[n], 64'd0);

    do_reset();
    a[0] = 3;
    b[0] = 5;
    tick();
    zero_in();
    check("single_first", 0, c[0], 64'd15);
    tick(); tick(); tick(); tick();
    check("single_c1", 0, c[0], 64'd15);
    check("single_c2", 1, c[1], 64'd0);
    check("single_c5", 4, c[4], 64'd0);
    check("single_c16", 15, c[15], 64'd0);

    for (int r = 0; r < 4; r++)
      for (int k = 0; k < 4; k++) begin
        ma[r][k] = 2;
        mb[r][k] = 3;
      end
    do_reset();
    run_prod(0, 3);
    check("full_c1_e4", 0, c[0], 64'd24);
    check("full_c16_e4", 15, c[15], 64'd0);
    run_prod(4, 8);
    check("full_c16_e9", 15, c[15], 64'd18);
    run_prod(9, 9);
    check_all("full_e10", 64'd24);
    tick(); tick();
    check_all("full_stable", 64'd24);

    for (int r = 0; r < 4; r++)
      for (int k = 0; k < 4; k++) begin
        ma[r][k] = (r == k) ? 32'd1 : 32'd0;
        mb[r][k] = 32'(4 * r + k + 1);
      end
    do_reset();
    run_prod(0, 9);
    for (int n = 0; n < 16; n++) check("identity", n, c[n], 64'(n + 1));

    do_reset();
    a[0] = 32'hFFFF_FFFF;
    b[0] = 32'hFFFF_FFFF;
    tick();
`ifdef SYST_SIGNED_EN
    check("wrap_1", 0, c[0], 64'd1);
`else
    check("wrap_1", 0, c[0], 64'hFFFF_FFFE_0000_0001);
`endif
    tick();
    zero_in();
`ifdef SYST_SIGNED_EN
    check("wrap_2", 0, c[0], 64'd2);
`else
    check("wrap_2", 0, c[0], 64'hFFFF_FFFC_0000_0002);
`endif

    for (int r = 0; r < 4; r++)
      for (int k = 0; k < 4; k++) begin
        ma[r][k] = 2;
        mb[r][k] = 3;
      end
    do_reset();
    run_prod(0, 4);
    check("midop_partial_c1", 0, c[0], 64'd24);
    rst = 0;
    #1;
    check_all("midop_reset", 64'd0);
    tick();
    rst = 1;
    run_prod(0, 9);
    check_all("midop_rerun", 64'd24);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
